// File: rtl/dcb_timer_if.sv
// ---------------------------------------------------------------------------
// dcb_timer_if
// Control/data bundle of the BCD countdown timer.
//   master : drives load/din/start/stop/en, observes out/zero/busy/done
//   slave  : the timer itself
// Signals:
//   dcbt_load   parallel-load strobe
//   dcbt_din    BCD preset, digit 0 in bits [3:0]
//   dcbt_start  begin/resume counting
//   dcbt_stop   pause counting
//   dcbt_en     one-cycle count tick
//   dcbt_out    current BCD count (registered)
//   dcbt_zero   count is all-zero digits
//   dcbt_busy   timer is not idle
//   dcbt_done   one-cycle completion pulse
// ---------------------------------------------------------------------------
interface dcb_timer_if #(
  parameter int DIGITS = 4
);
  logic                  dcbt_load;
  logic [4*DIGITS-1:0]   dcbt_din;
  logic                  dcbt_start;
  logic                  dcbt_stop;
  logic                  dcbt_en;
  logic [4*DIGITS-1:0]   dcbt_out;
  logic                  dcbt_zero;
  logic                  dcbt_busy;
  logic                  dcbt_done;

  modport master (
    output dcbt_load, dcbt_din, dcbt_start, dcbt_stop, dcbt_en,
    input  dcbt_out, dcbt_zero, dcbt_busy, dcbt_done
  );

  modport slave (
    input  dcbt_load, dcbt_din, dcbt_start, dcbt_stop, dcbt_en,
    output dcbt_out, dcbt_zero, dcbt_busy, dcbt_done
  );
endinterface

// File: rtl/dcb_timer.sv
// ---------------------------------------------------------------------------
// dcb_timer
// Multi-digit BCD down counter. A load captures a (digit-clamped) preset,
// start begins counting, each en tick while running removes one count with
// BCD borrow across digits. Reaching zero raises a one-cycle done pulse and,
// when AUTO_RELOAD is set and the preset is non-zero, restarts from the preset.
// Ports:
//   dcbt_clk  system clock, rising edge
//   dcbt_rst  synchronous active-high reset
//   bus       dcb_timer_if slave modport (load/din/start/stop/en in,
//             out/zero/busy/done out)
// Parameters:
//   DIGITS       number of BCD digits (count width 4*DIGITS)
//   AUTO_RELOAD  1 = reload preset after done, 0 = stop at zero
// ---------------------------------------------------------------------------
module dcb_timer #(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic         dcbt_clk,
  input  logic         dcbt_rst,
  dcb_timer_if.slave   bus
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   count_reg, count_next;
  logic [W-1:0]   preset_reg, preset_next;

  logic [W-1:0]       din_clamped;
  logic [W-1:0]       count_dec;
  logic [DIGITS-1:0]  borrow;      // borrow into each digit
  logic               count_is_zero;
  logic               count_is_one;

  assign count_is_zero = (count_reg == '0);
  assign count_is_one  = (count_reg == W'(1));

  // Digit 0 always receives the decrement; the borrow ripples upward only
  // through digits that are currently 0 (they wrap to 9).
  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] din_digit;
      logic [3:0] cnt_digit;

      assign din_digit = bus.dcbt_din[4*gi +: 4];
      assign cnt_digit = count_reg[4*gi +: 4];

      // Non-decimal nibbles A-F are clamped to 9 digit by digit.
      assign din_clamped[4*gi +: 4] = (din_digit > 4'd9) ? 4'd9 : din_digit;

      assign count_dec[4*gi +: 4] = !borrow[gi]        ? cnt_digit :
                                    (cnt_digit == 4'd0) ? 4'd9     :
                                                          cnt_digit - 4'd1;

      if (gi < DIGITS - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (cnt_digit == 4'd0);
      end
    end
  endgenerate

  // State register
  always_ff @(posedge dcbt_clk) begin
    if (dcbt_rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      preset_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      preset_reg <= preset_next;
    end
  end

  // Next-state logic; priority load > stop > start > en.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    preset_next = preset_reg;
    if (bus.dcbt_load) begin
      count_next  = din_clamped;
      preset_next = din_clamped;
      state_next  = ST_IDLE;
    end else if (bus.dcbt_stop) begin
      // Pausing holds the count in every state, including the done cycle.
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.dcbt_start) begin
            // A zero count completes immediately without any decrement.
            state_next = count_is_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // Zero is never decremented, so the count cannot wrap to all nines.
          if (bus.dcbt_en && !count_is_zero) begin
            count_next = count_dec;
            if (count_is_one) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if ((AUTO_RELOAD != 0) && (preset_reg != '0)) begin
            count_next = preset_reg;
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.dcbt_out  = count_reg;
    bus.dcbt_zero = count_is_zero;
    bus.dcbt_busy = (state_reg != ST_IDLE);
    bus.dcbt_done = (state_reg == ST_DONE);
  end

endmodule

// File: tb/tb_dcb_timer.sv
// ---------------------------------------------------------------------------
// tb_dcb_timer
// Drives two timers (AUTO_RELOAD 0 and 1) with identical stimulus and checks
// both against an integer-valued reference model of the countdown rules.
// ---------------------------------------------------------------------------
module tb_dcb_timer;

  localparam int DIGITS  = 4;
  localparam int W       = 4 * DIGITS;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic         clk = 1'b0;
  logic         rst_s = 1'b1;
  logic         load_s = 1'b0;
  logic [W-1:0] din_s = '0;
  logic         start_s = 1'b0;
  logic         stop_s = 1'b0;
  logic         en_s = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain decimal value, preset, phase
  int m_val[2];
  int m_pre[2];
  int m_ph[2];
  int m_ar[2];

  always #5 clk = ~clk;

  dcb_timer_if #(.DIGITS(DIGITS)) if0 ();
  dcb_timer_if #(.DIGITS(DIGITS)) if1 ();

  assign if0.dcbt_load  = load_s;
  assign if0.dcbt_din   = din_s;
  assign if0.dcbt_start = start_s;
  assign if0.dcbt_stop  = stop_s;
  assign if0.dcbt_en    = en_s;
  assign if1.dcbt_load  = load_s;
  assign if1.dcbt_din   = din_s;
  assign if1.dcbt_start = start_s;
  assign if1.dcbt_stop  = stop_s;
  assign if1.dcbt_en    = en_s;

  dcb_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(0)) u_dut0 (
    .dcbt_clk (clk),
    .dcbt_rst (rst_s),
    .bus      (if0)
  );

  dcb_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1)) u_dut1 (
    .dcbt_clk (clk),
    .dcbt_rst (rst_s),
    .bus      (if1)
  );

  logic [W+2:0] act0, act1;
  assign act0 = {if0.dcbt_out, if0.dcbt_zero, if0.dcbt_busy, if0.dcbt_done};
  assign act1 = {if1.dcbt_out, if1.dcbt_zero, if1.dcbt_busy, if1.dcbt_done};

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_value(input logic [W-1:0] d);
    int v;
    int nib;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = int'(d[4*i +: 4]);
      if (nib > 9) nib = 9;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  function automatic logic [W+2:0] exp_vec(input int idx);
    return {to_bcd(m_val[idx]), (m_val[idx] == 0), (m_ph[idx] != PH_IDLE),
            (m_ph[idx] == PH_DONE)};
  endfunction

  function automatic void model_step(input int idx);
    if (rst_s) begin
      m_val[idx] = 0; m_pre[idx] = 0; m_ph[idx] = PH_IDLE;
    end else if (load_s) begin
      m_val[idx] = clamp_value(din_s);
      m_pre[idx] = m_val[idx];
      m_ph[idx]  = PH_IDLE;
    end else if (stop_s) begin
      m_ph[idx] = PH_IDLE;
    end else if (m_ph[idx] == PH_IDLE) begin
      if (start_s) m_ph[idx] = (m_val[idx] == 0) ? PH_DONE : PH_RUN;
    end else if (m_ph[idx] == PH_RUN) begin
      if (en_s && m_val[idx] > 0) begin
        m_val[idx] = m_val[idx] - 1;
        if (m_val[idx] == 0) m_ph[idx] = PH_DONE;
      end
    end else begin
      if (m_ar[idx] != 0 && m_pre[idx] != 0) begin
        m_val[idx] = m_pre[idx];
        m_ph[idx]  = PH_RUN;
      end else begin
        m_ph[idx] = PH_IDLE;
      end
    end
  endfunction

  task automatic drive(input logic l, input logic [W-1:0] d, input logic s,
                       input logic p, input logic e);
    load_s = l; din_s = d; start_s = s; stop_s = p; en_s = e;
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    rst_s = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (act0 !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL reset_dut0 got=%h required=%h", act0, {16'h0000, 3'b100}); end
    checks++; if (act1 !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL reset_dut1 got=%h required=%h", act1, {16'h0000, 3'b100}); end
    rst_s = 1'b0;
    $display("test_reset: out=%h zero=%b busy=%b", if0.dcbt_out, if0.dcbt_zero, if0.dcbt_busy);
  endtask

  task automatic test_countdown();
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0); tick();
    // en alongside start must not be counted
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h0003 || if0.dcbt_busy !== 1'b1) begin errors++; $display("FAIL cd_start got out=%h busy=%b required out=0003 busy=1", if0.dcbt_out, if0.dcbt_busy); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      tick();
      checks++; if (if0.dcbt_out !== to_bcd(i) || if0.dcbt_done !== (i == 0)) begin errors++; $display("FAIL cd_tick%0d got out=%h done=%b required out=%h done=%b", i, if0.dcbt_out, if0.dcbt_done, to_bcd(i), (i == 0)); end
      checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL cd_dut1 got=%h required=%h", act1, exp_vec(1)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
    checks++; if (act0 !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL cd_after_done got=%h required=%h", act0, {16'h0000, 3'b100}); end
    checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL cd_after_done_dut1 got=%h required=%h", act1, exp_vec(1)); end
    $display("test_countdown: out=%h busy=%b", if0.dcbt_out, if0.dcbt_busy);
  endtask

  task automatic test_borrow();
    drive(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h0999) begin errors++; $display("FAIL borrow_0999 got=%h required=0999", if0.dcbt_out); end
    tick();
    checks++; if (if0.dcbt_out !== 16'h0998) begin errors++; $display("FAIL borrow_0998 got=%h required=0998", if0.dcbt_out); end
    $display("test_borrow: out=%h", if0.dcbt_out);
  endtask

  task automatic test_clamp();
    drive(1'b1, 16'hA5FC, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h9599 || if0.dcbt_busy !== 1'b0) begin errors++; $display("FAIL clamp got out=%h busy=%b required out=9599 busy=0", if0.dcbt_out, if0.dcbt_busy); end
    checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL clamp_dut1 got=%h required=%h", act1, exp_vec(1)); end
    $display("test_clamp: out=%h", if0.dcbt_out);
  endtask

  task automatic test_stop_resume();
    drive(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick(); tick();
    checks++; if (if0.dcbt_out !== 16'h0048) begin errors++; $display("FAIL stop_pre got=%h required=0048", if0.dcbt_out); end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h0048 || if0.dcbt_busy !== 1'b0) begin errors++; $display("FAIL stop_hold got out=%h busy=%b required out=0048 busy=0", if0.dcbt_out, if0.dcbt_busy); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h0047 || if0.dcbt_busy !== 1'b1) begin errors++; $display("FAIL resume got out=%h busy=%b required out=0047 busy=1", if0.dcbt_out, if0.dcbt_busy); end
    $display("test_stop_resume: out=%h", if0.dcbt_out);
  endtask

  task automatic test_rst_mid();
    rst_s = 1'b1; tick(); rst_s = 1'b0;
    checks++; if (act0 !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL rst_mid got=%h required=%h", act0, {16'h0000, 3'b100}); end
    $display("test_rst_mid: out=%h busy=%b", if0.dcbt_out, if0.dcbt_busy);
  endtask

  task automatic test_auto_reload();
    drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int rep = 0; rep < 2; rep++) begin
      tick(); tick();
      checks++; if (if1.dcbt_out !== 16'h0000 || if1.dcbt_done !== 1'b1) begin errors++; $display("FAIL ar_done%0d got out=%h done=%b required out=0000 done=1", rep, if1.dcbt_out, if1.dcbt_done); end
      tick();
      checks++; if (if1.dcbt_out !== 16'h0002 || if1.dcbt_busy !== 1'b1 || if1.dcbt_done !== 1'b0) begin errors++; $display("FAIL ar_reload%0d got out=%h busy=%b done=%b required out=0002 busy=1 done=0", rep, if1.dcbt_out, if1.dcbt_busy, if1.dcbt_done); end
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL ar_dut0 got=%h required=%h", act0, exp_vec(0)); end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("test_auto_reload: out=%h busy=%b", if1.dcbt_out, if1.dcbt_busy);
  endtask

  task automatic test_zero_start();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1); tick();
    checks++; if (act0 !== {16'h0000, 1'b1, 1'b1, 1'b1}) begin errors++; $display("FAIL zero_start got=%h required=%h", act0, {16'h0000, 3'b111}); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
    checks++; if (act0 !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL zero_after got=%h required=%h", act0, {16'h0000, 3'b100}); end
    $display("test_zero_start: done pulse seen");
  endtask

  task automatic test_load_priority();
    drive(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0315, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (if0.dcbt_out !== 16'h0315 || if0.dcbt_busy !== 1'b0) begin errors++; $display("FAIL load_prio got out=%h busy=%b required out=0315 busy=0", if0.dcbt_out, if0.dcbt_busy); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("test_load_priority: out=%h", if0.dcbt_out);
  endtask

  task automatic test_random();
    int local_err;
    local_err = errors;
    for (int n = 0; n < 600; n++) begin
      rst_s   = ($urandom_range(0, 99) == 0);
      load_s  = ($urandom_range(0, 19) == 0);
      din_s   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 16'h0025));
      stop_s  = ($urandom_range(0, 15) == 0);
      start_s = ($urandom_range(0, 3) == 0);
      en_s    = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL rand_dut0 n=%0d got=%h required=%h", n, act0, exp_vec(0)); end
      checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL rand_dut1 n=%0d got=%h required=%h", n, act1, exp_vec(1)); end
    end
    rst_s = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("test_random: 600 cycles, %0d new errors", errors - local_err);
  endtask

  initial begin
    m_ar[0] = 0; m_ar[1] = 1;
    m_val[0] = 0; m_val[1] = 0;
    m_pre[0] = 0; m_pre[1] = 0;
    m_ph[0] = PH_IDLE; m_ph[1] = PH_IDLE;
    test_reset();
    test_countdown();
    test_borrow();
    test_clamp();
    test_stop_resume();
    test_rst_mid();
    test_auto_reload();
    test_zero_start();
    test_load_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
